// File: rtl/stream_demux_register_pkg.sv
// stream_demux_pkg: shared slot state and select encoding for the stream demux
package stream_demux_pkg;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
  localparam logic SEL_OUT1 = 1'b1;
  localparam logic SEL_OUT2 = 1'b0;
endpackage

// File: rtl/stream_demux_register_if.sv
// stream_demux_register_if: producer-side and both consumer-side handshakes of the demux
interface stream_demux_register_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid, in_ready, data_select;
  logic [WIDTH-1:0] in_data;
  logic             out1_valid, out1_ready, out2_valid, out2_ready;
  logic [WIDTH-1:0] out1_data, out2_data;
  logic [CNT_W-1:0] cnt1, cnt2;
  modport master (
    output in_valid, in_data, data_select, out1_ready, out2_ready,
    input  in_ready, out1_valid, out1_data, out2_valid, out2_data, cnt1, cnt2
  );
  modport slave (
    input  in_valid, in_data, data_select, out1_ready, out2_ready,
    output in_ready, out1_valid, out1_data, out2_valid, out2_data, cnt1, cnt2
  );
endinterface

// File: rtl/stream_demux_register_slot.sv
// demux_slot: one-entry holding register with EMPTY/FULL state and transfer counter
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt,
  output logic             space_avail
);
  slot_state_t state;
  logic        drain;
  assign out_valid   = state == SLOT_FULL;
  assign drain       = out_valid && out_ready;
  assign space_avail = state == SLOT_EMPTY || out_ready;
  // slot state, payload (loaded only on accept) and handshake count
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
      cnt      <= '0;
    end else begin
      state <= load ? SLOT_FULL : drain ? SLOT_EMPTY : state;
      if (load) out_data <= load_data;
      if (drain) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/stream_demux_register.sv
// stream_demux_register: registered 1-to-2 stream demultiplexer with per-output counters
module stream_demux_register
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rstN,
  stream_demux_register_if.slave bus
);
  logic sp1, sp2, accept, to1;
  assign to1          = bus.data_select == SEL_OUT1;
  assign bus.in_ready = rstN && (to1 ? sp1 : sp2);
  assign accept       = bus.in_valid && bus.in_ready;
  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk(clk), .rstN(rstN), .load(accept && to1), .load_data(bus.in_data),
    .out_ready(bus.out1_ready), .out_valid(bus.out1_valid), .out_data(bus.out1_data),
    .cnt(bus.cnt1), .space_avail(sp1)
  );
  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot2 (
    .clk(clk), .rstN(rstN), .load(accept && !to1), .load_data(bus.in_data),
    .out_ready(bus.out2_ready), .out_valid(bus.out2_valid), .out_data(bus.out2_data),
    .cnt(bus.cnt2), .space_avail(sp2)
  );
endmodule

// File: tb/tb_stream_demux_register.sv
// tb_stream_demux_register: randomized and directed checks against a queue-based model
module tb_stream_demux_register;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;
  stream_demux_register_if #(.WIDTH(4), .CNT_W(8)) bus ();
  stream_demux_register #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rstN(rstN), .bus(bus));
  logic [3:0] q1[$], q2[$];
  logic [7:0] m1, m2;
  int total = 0;
  int passed = 0;
  task automatic apply_reset();
    rstN = 1'b0;
    bus.in_valid = 1'b0; bus.data_select = 1'b0; bus.in_data = '0;
    bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;
    #7;
    q1.delete(); q2.delete(); m1 = '0; m2 = '0;
    @(negedge clk) rstN = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic cycle(input logic v, input logic s, input logic [3:0] d, input logic r1, input logic r2);
    logic er, dr1, dr2;
    bus.in_valid = v; bus.data_select = s; bus.in_data = d;
    bus.out1_ready = r1; bus.out2_ready = r2;
    #1;
    er = s ? (q1.size() == 0 || r1) : (q2.size() == 0 || r2);
    if (v) begin
      total++;
      if (bus.in_ready !== er) $display("FAIL in_ready: got %b exp %b", bus.in_ready, er);
      else passed++;
    end
    dr1 = q1.size() > 0 && r1;
    dr2 = q2.size() > 0 && r2;
    @(posedge clk);
    if (dr1) begin void'(q1.pop_front()); m1++; end
    if (dr2) begin void'(q2.pop_front()); m2++; end
    if (v && er) begin
      if (s) q1.push_back(d);
      else q2.push_back(d);
    end
    #1;
    total++;
    if (bus.out1_valid !== (q1.size() > 0) || (q1.size() > 0 && bus.out1_data !== q1[0]))
      $display("FAIL out1: got v=%b d=%h exp v=%b d=%h", bus.out1_valid, bus.out1_data, q1.size() > 0, q1.size() > 0 ? q1[0] : 4'h0);
    else passed++;
    total++;
    if (bus.out2_valid !== (q2.size() > 0) || (q2.size() > 0 && bus.out2_data !== q2[0]))
      $display("FAIL out2: got v=%b d=%h exp v=%b d=%h", bus.out2_valid, bus.out2_data, q2.size() > 0, q2.size() > 0 ? q2[0] : 4'h0);
    else passed++;
    total++;
    if (bus.cnt1 !== m1 || bus.cnt2 !== m2)
      $display("FAIL counters: got %0d/%0d exp %0d/%0d", bus.cnt1, bus.cnt2, m1, m2);
    else passed++;
  endtask
  task automatic test_reset();
    apply_reset();
    cycle(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
    bus.in_valid = 1'b1; bus.data_select = 1'b1;
    #2 rstN = 1'b0;
    #1;
    total++;
    if ({bus.out1_valid, bus.out2_valid, bus.in_ready} !== 3'b000 || bus.out1_data !== 4'h0 ||
        bus.out2_data !== 4'h0 || bus.cnt1 !== 8'h0 || bus.cnt2 !== 8'h0)
      $display("FAIL async_reset: got v1=%b v2=%b rdy=%b d1=%h d2=%h c1=%0d c2=%0d exp all 0",
               bus.out1_valid, bus.out2_valid, bus.in_ready, bus.out1_data, bus.out2_data, bus.cnt1, bus.cnt2);
    else passed++;
    q1.delete(); q2.delete(); m1 = '0; m2 = '0;
    @(negedge clk) rstN = 1'b1;
    bus.in_valid = 1'b0; bus.data_select = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL ready_after_reset_sel1: got %b exp 1", bus.in_ready);
    else passed++;
    bus.data_select = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL ready_after_reset_sel0: got %b exp 1", bus.in_ready);
    else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_routing();
    apply_reset();
    cycle(1'b1, 1'b1, 4'hA, 1'b1, 1'b1);
    total++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 4'hA) $display("FAIL route_out1: got %b/%h exp 1/a", bus.out1_valid, bus.out1_data);
    else passed++;
    cycle(1'b1, 1'b0, 4'h5, 1'b1, 1'b1);
    total++;
    if (bus.out2_valid !== 1'b1 || bus.out2_data !== 4'h5) $display("FAIL route_out2: got %b/%h exp 1/5", bus.out2_valid, bus.out2_data);
    else passed++;
    cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    total++;
    if (bus.cnt1 !== 8'd1 || bus.cnt2 !== 8'd1) $display("FAIL route_counts: got %0d/%0d exp 1/1", bus.cnt1, bus.cnt2);
    else passed++;
  endtask
  task automatic test_backpressure();
    cycle(1'b1, 1'b1, 4'h3, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
    total++;
    if (bus.out1_data !== 4'h3 || bus.out1_valid !== 1'b1) $display("FAIL stall_hold: got %b/%h exp 1/3", bus.out1_valid, bus.out1_data);
    else passed++;
    bus.in_valid = 1'b1; bus.data_select = 1'b1; bus.in_data = 4'h7; bus.out1_ready = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) $display("FAIL stall_ready: got %b exp 0", bus.in_ready);
    else passed++;
    cycle(1'b1, 1'b1, 4'h7, 1'b1, 1'b1);
    total++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 4'h7) $display("FAIL drain_load: got %b/%h exp 1/7", bus.out1_valid, bus.out1_data);
    else passed++;
  endtask
  task automatic test_other_path();
    cycle(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
    total++;
    if (bus.out2_data !== 4'hC || bus.out1_data !== 4'h7 || bus.out1_valid !== 1'b1)
      $display("FAIL other_path: got d2=%h d1=%h v1=%b exp c/7/1", bus.out2_data, bus.out1_data, bus.out1_valid);
    else passed++;
  endtask
  task automatic test_simultaneous_drain();
    logic [7:0] c1, c2;
    c1 = bus.cnt1; c2 = bus.cnt2;
    cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    total++;
    if (bus.out1_valid !== 1'b0 || bus.out2_valid !== 1'b0 || bus.cnt1 !== c1 + 8'd1 || bus.cnt2 !== c2 + 8'd1)
      $display("FAIL both_drain: got v=%b%b c=%0d/%0d exp 00 %0d/%0d", bus.out1_valid, bus.out2_valid, bus.cnt1, bus.cnt2, c1 + 8'd1, c2 + 8'd1);
    else passed++;
  endtask
  task automatic test_streaming();
    apply_reset();
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 4'(i), 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    total++;
    if (bus.cnt2 !== 8'd44 || bus.cnt1 !== 8'd0) $display("FAIL stream_count: got %0d/%0d exp 0/44", bus.cnt1, bus.cnt2);
    else passed++;
  endtask
  task automatic test_random();
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask
  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_other_path();
    test_simultaneous_drain();
    test_streaming();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stream_demux_register.md
Name: stream_demux_register

Overview:
- Registered 1-to-2 demultiplexer. A single input stream with a valid/ready handshake is steered to one of two output streams by `data_select`.
- It is the inverse direction of the team's muxed register: one source feeds two sinks, where the mux feeds two sources into one register.
- It sits between a shared producer and two independent consumers. Each output has one holding register, so output timing is registered.
- Per-output transfer counters support debug and throughput checks.

Parameters:
- WIDTH, 4, data width of input and both outputs.
- CNT_W, 8, width of each per-output transfer counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstN  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has data on in_data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  input payload.
- data_select  input  1  route for the current input beat: 1 = out1, 0 = out2. Sampled only when in_valid is high.
- out1_valid  output  1  out1 holding register full.
- out1_ready  input  1  consumer 1 accepts.
- out1_data  output  WIDTH  out1 payload.
- out2_valid  output  1  out2 holding register full.
- out2_ready  input  1  consumer 2 accepts.
- out2_data  output  WIDTH  out2 payload.
- cnt1  output  CNT_W  completed out1 transfers, modulo 2^CNT_W.
- cnt2  output  CNT_W  completed out2 transfers, modulo 2^CNT_W.

Behaviour:
- Reset (rstN low, asynchronous assert, synchronous-clocked release): all outputs are 0. This covers out1/2_valid, out1/2_data, cnt1, cnt2 and in_ready.
- Reset mid-operation discards held data. There is no replay.
- Each output slot is a 2-state FSM, EMPTY and FULL:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain (outN_valid && outN_ready) without a simultaneous load.
  - FULL stays FULL on drain plus load in the same cycle; the slot takes the new data.
  - FULL stays FULL on no drain and no load; data is held stable.
- outN_valid equals (state == FULL).
- in_ready is combinational:
  - data_select ? (slot1 EMPTY || out1_ready) : (slot2 EMPTY || out2_ready).
  - When in_valid is low, in_ready is still driven from data_select but is don't-care.
- Accept occurs when in_valid && in_ready. The selected slot loads in_data on that clock edge.
- Latency: an input accepted at edge N presents outN_valid/data after edge N.
- Throughput: one beat per cycle per path when the consumer keeps ready high.
- The non-selected slot is unaffected by the input; it can drain in the same cycle.
- Both slots may drain in the same cycle.
- Stability rule: while outN_valid && !outN_ready, outN_data and outN_valid do not change.
- Head-of-line blocking is intended:
  - A beat destined for a FULL, stalled slot holds in_ready low.
  - Data is never dropped or reordered within a path.
- Counters:
  - cntN increments by 1 on each outN handshake.
  - It wraps from 2^CNT_W-1 to 0 with no saturation flag.
- No X propagation: data registers load only on accept and never on idle cycles.

Decomposition:
- Package stream_demux_pkg holds:
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t.
  - Localparams for select encoding: SEL_OUT1 = 1'b1, SEL_OUT2 = 1'b0.
- Sub-module demux_slot is instantiated twice. It contains:
  - one holding register and its FSM;
  - the transfer counter;
  - the load, out_ready and space_avail ports.
- The top level contains only the select decode and the in_ready mux.

Test Plan:
- Reset: assert rstN low mid-stream with both slots FULL -> all outputs 0 immediately, without waiting for a clock edge; after release, in_ready=1 for both selects.
- Routing, WIDTH=4: send 4'hA with data_select=1, then 4'h5 with data_select=0, both outN_ready=1 -> out1_data=4'hA one cycle after accept, then out2_data=4'h5; cnt1=1, cnt2=1.
- Backpressure: hold out1_ready=0, send 4'h3 then 4'h7 to out1 -> 4'h3 held stable on out1; in_ready=0 for the 4'h7 beat. Raise out1_ready -> 4'h3 transfers, 4'h7 loads in the same cycle, out1_valid stays 1.
- Non-blocking other path: while out1 is stalled FULL, send 4'hC with data_select=0 -> accepted; out2_data=4'hC the next cycle; out1 is unchanged.
- Streaming: 300 back-to-back beats to out2 with out2_ready=1 and CNT_W=8 -> in_ready held 1, one beat per cycle, data order preserved, cnt2 wraps 255->0 and ends at 44.
- Simultaneous drain: both slots FULL, assert out1_ready and out2_ready in the same cycle with in_valid=0 -> both valid fall next cycle; cnt1 and cnt2 each increment by 1.
